// File: rtl/pipelined_csa_adder.sv
// pipelined_csa_adder: carry-select adder/subtractor resolving one BLK-bit block per pipeline stage
module pipelined_csa_adder #(
    parameter int WIDTH = 32,
    parameter int BLK   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NBLK = WIDTH / BLK;

    logic adv;

    if (WIDTH % BLK != 0) begin : g_chk
        $error("WIDTH must be a multiple of BLK");
    end

    for (genvar k = 0; k < NBLK; k++) begin : g
        logic             v, c;
        logic [WIDTH-1:0] ra, rb, rs;
        logic             xv, xc;
        logic [WIDTH-1:0] xa, xb, xs;
        logic [BLK:0]     p0, p1;
        if (k == 0) begin : g_in
            assign xv = in_valid;
            assign xa = a;
            assign xb = sub ? ~b : b;
            assign xc = sub | cin;
            assign xs = '0;
        end else begin : g_mid
            assign xv = g[k-1].v;
            assign xa = g[k-1].ra;
            assign xb = g[k-1].rb;
            assign xc = g[k-1].c;
            assign xs = g[k-1].rs;
        end
        assign p0 = {1'b0, xa[k*BLK +: BLK]} + {1'b0, xb[k*BLK +: BLK]};
        assign p1 = {1'b0, xa[k*BLK +: BLK]} + {1'b0, xb[k*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
        // stage k: select the precomputed block sum with the incoming carry, forward operands and resolved bits
        always_ff @(posedge clk) begin
            if (rst) begin
                v  <= 1'b0;
                c  <= 1'b0;
                ra <= '0;
                rb <= '0;
                rs <= '0;
            end else if (adv) begin
                v  <= xv;
                c  <= xc ? p1[BLK] : p0[BLK];
                ra <= xa;
                rb <= xb;
                rs <= xs;
                rs[k*BLK +: BLK] <= xc ? p1[BLK-1:0] : p0[BLK-1:0];
            end
        end
    end

    assign adv       = ~out_valid | out_ready;
    assign in_ready  = adv;
    assign out_valid = g[NBLK-1].v;
    assign sum       = g[NBLK-1].rs;
    assign cout      = g[NBLK-1].c;
    // carry into the MSB is recovered from the MSB operand bits and sum bit
    assign ovf       = g[NBLK-1].ra[WIDTH-1] ^ g[NBLK-1].rb[WIDTH-1] ^ sum[WIDTH-1] ^ cout;
endmodule

// File: tb/tb_pipelined_csa_adder.sv
// tb_pipelined_csa_adder: scoreboard bench for pipelined_csa_adder
module tb_pipelined_csa_adder;
    localparam int W = 32;

    logic         clk = 1'b0, rst = 1'b1;
    logic         in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, cout, ovf;
    logic [W-1:0] sum;

    logic         s_valid = 1'b0;
    logic [15:0]  s_a = '0, s_b = '0;
    logic         r16_irdy, r16_v, r16_co, r16_ov, r4_irdy, r4_v, r4_co, r4_ov;
    logic [15:0]  r16_s, r4_s;

    int           total = 0, bad = 0;
    logic [33:0]  q[$];
    bit           armed = 0, rand_rdy = 0, stall = 0;

    always #5 clk = ~clk;

    pipelined_csa_adder #(.WIDTH(32), .BLK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf));

    pipelined_csa_adder #(.WIDTH(16), .BLK(16)) d16 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(r16_irdy), .a(s_a), .b(s_b),
        .cin(1'b0), .sub(1'b0), .out_valid(r16_v), .out_ready(1'b1),
        .sum(r16_s), .cout(r16_co), .ovf(r16_ov));

    pipelined_csa_adder #(.WIDTH(16), .BLK(4)) d4 (
        .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(r4_irdy), .a(s_a), .b(s_b),
        .cin(1'b0), .sub(1'b0), .out_valid(r4_v), .out_ready(1'b1),
        .sum(r4_s), .cout(r4_co), .ovf(r4_ov));

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endtask

    // reference: plain signed/unsigned arithmetic, packed as {cout, ovf, sum}
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
        longint      sx, sy, r;
        logic [32:0] u;
        logic        co, ov;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = s ? sx - sy : sx + sy + longint'(ci);
        ov = (r < -(longint'(1) << 31)) || (r >= (longint'(1) << 31));
        u  = {1'b0, x} + {1'b0, y} + {32'b0, ci};
        co = s ? (x >= y) : u[32];
        return {co, ov, r[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    // consumer handshake driver
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : !stall;
    end

    // monitor: push on acceptance, pop and compare on result transfer, check hold stability
    initial begin
        logic [33:0] ph, e;
        bit          hold;
        hold = 0;
        ph   = '0;
        forever begin
            @(negedge clk);
            if (!armed) continue;
            if (hold) chk("hold_stable", {31'b0, out_valid, cout, ovf, sum}, {31'b0, 1'b1, ph});
            hold = out_valid && !out_ready;
            ph   = {cout, ovf, sum};
            if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result got=%0h exp=none", sum);
                end else begin
                    e = q.pop_front();
                    chk("result", {30'b0, cout, ovf, sum}, {30'b0, e});
                end
            end
        end
    end

    // called and returns at posedge+1
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
        bit acc;
        a = x;
        b = y;
        cin = ci;
        sub = s;
        in_valid = 1'b1;
        for (int i = 0; ; i++) begin
            if (i == 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout got=stuck exp=accept");
                break;
            end
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt, l16, l4;
        logic [15:0] s16, s4;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_outputs", {30'b0, cout, ovf, sum}, 64'd0);
        rst = 1'b0;
        chk("in_ready_after_rst", {63'b0, in_ready}, 64'd1);
        armed = 1;

        s_a = 16'd655;
        s_b = 16'd1;
        s_valid = 1'b1;
        @(negedge clk);
        chk("small_in_ready", {62'b0, r16_irdy, r4_irdy}, 64'd3);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        l16 = -1;
        l4 = -1;
        s16 = '0;
        s4 = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (r16_v && l16 < 0) begin l16 = i; s16 = r16_s; end
            if (r4_v && l4 < 0) begin l4 = i; s4 = r4_s; end
        end
        chk("lat_blk16", 64'(l16), 64'd0);
        chk("sum_blk16", 64'(s16), 64'd656);
        chk("lat_blk4", 64'(l4), 64'd3);
        chk("sum_blk4", 64'(s4), 64'd656);
        @(posedge clk);
        #1;

        send(32'd4, 32'd5, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
            cnt++;
        end
        chk("latency", 64'(cnt), 64'd3);
        @(posedge clk);
        #1;
        drain();

        send(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
        send(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0);
        send(32'd5, 32'd7, 1'b1, 1'b1);
        send(32'h80000000, 32'h1, 1'b0, 1'b1);
        drain();

        fork
            for (int i = 0; i < 6; i++) send(32'(8 + i), 32'(6 + 3 * i), 1'b1, 1'b0);
            begin
                for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
                repeat (2) @(negedge clk);
                stall = 1;
                @(negedge clk);
                chk("stall_out_ready", {63'b0, out_ready}, 64'd0);
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
                end
                stall = 0;
            end
        join
        drain();

        send(32'd100, 32'd1, 1'b0, 1'b0);
        send(32'd200, 32'd2, 1'b0, 1'b0);
        send(32'd300, 32'd3, 1'b0, 1'b0);
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("midrst_outputs", {30'b0, cout, ovf, sum}, 64'd0);
        chk("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        repeat (8) @(posedge clk);
        #1;
        send(32'd4, 32'd8, 1'b0, 1'b0);
        drain();

        rand_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end else begin
                send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end
        rand_rdy = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipelined_csa_adder.md
PIPELINED_CSA_ADDER -- requirements
Module: pipelined_csa_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 Parameter BLK, default 8: carry-select block width; WIDTH % BLK == 0 SHALL hold, else elaboration error; NBLK = WIDTH/BLK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in_valid  input  1  operand set present on a, b, cin, sub.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  WIDTH  operand A, unsigned/two's-complement.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in, add mode only.
REQ-010 sub  input  1  0 = a+b+cin, 1 = a-b.
REQ-011 out_valid  output  1  sum/cout/ovf hold a valid result.
REQ-012 out_ready  input  1  consumer accepts result this cycle.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry-out of MSB (sub: 1 = no borrow).
REQ-015 ovf  output  1  signed two's-complement overflow.

Function
REQ-016 Pipeline SHALL have NBLK stages; stage k resolves block k (bits k*BLK+BLK-1 .. k*BLK).
REQ-017 Each stage SHALL precompute block sums for carry 0 and carry 1 and select with the registered carry of stage k-1 (stage 0 uses effective carry-in).
REQ-018 Effective B = sub ? ~b : b; effective carry-in = sub ? 1 : cin; cin ignored when sub=1.
REQ-019 Operand bits of blocks not yet resolved SHALL be carried forward in skew registers; resolved sum bits SHALL be carried forward in deskew registers so sum emerges aligned.
REQ-020 Each stage SHALL carry a valid bit; bubbles propagate as invalid stages.
REQ-021 advance = ~out_valid | out_ready; when advance=1 all stages shift one position; when 0 all stages and outputs hold.
REQ-022 in_ready = advance; a transfer occurs when in_valid & in_ready.
REQ-023 Latency: a transfer at edge N SHALL present its result with out_valid=1 after edge N+NBLK-1 (visible NBLK cycles after acceptance, unstalled); NBLK=1 gives one-cycle latency.
REQ-024 Throughput: one result per cycle with out_ready held high; results in acceptance order, none dropped or duplicated.
REQ-025 cout = carry out of block NBLK-1; ovf = carry into MSB XOR carry out of MSB.
REQ-026 in_valid=0 with advance=1 SHALL insert a bubble; sum/cout/ovf values with out_valid=0 are don't-care except after reset.
REQ-027 sum, cout, ovf SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-028 rst=1 at an edge SHALL clear all stage valid bits, out_valid, sum, cout, ovf to 0 at that edge.
REQ-029 Reset mid-operation SHALL discard all in-flight operands; no result from before reset SHALL appear after.
REQ-030 in_ready SHALL be 1 in the cycle following reset release (out_valid=0).
REQ-031 Skew/deskew data registers need not be reset.

Verification
REQ-032 WIDTH=32, BLK=8, out_ready=1: a=4, b=5, cin=0, sub=0 -> 4 cycles later sum=9, cout=0, ovf=0.
REQ-033 WIDTH=32, BLK=8: a=0xFFFFFFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0 (carry crosses all blocks); a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, ovf=1.
REQ-034 Sub mode: a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0; a=0x80000000, b=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
REQ-035 Back-to-back 6 operands (8+6+1, 9+9+1, ...) with out_ready dropped 3 cycles after first result -> in_ready=0 during stall, outputs frozen, all 6 results later emitted in order, correct.
REQ-036 Reset asserted with 3 operands in flight -> out_valid=0 next cycle, no stale result ever emitted, next accepted operand 4+8 -> 12.
REQ-037 WIDTH=16, BLK=16: a=655, b=1, cin=0 -> sum=656 one cycle after acceptance; WIDTH=16, BLK=4 same stimulus -> sum=656 after 4 cycles.
